// File: rtl/seven_seg_pkg.sv
// Shared constants and state encoding for the 7-segment scan multiplexer.
package seven_seg_pkg;

    localparam int unsigned SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        ON    = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_slot_timer.sv
// Per-slot cycle counter with guard/slot end strobes and a next-cycle duty (lit) qualifier.
module scan_slot_timer #(
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned GUARD_CYCLES = 500,
    parameter int unsigned LIMIT_W      = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [LIMIT_W-1:0] lit_limit,
    output logic               guard_done_c,
    output logic               slot_done_c,
    output logic               lit_next_c
);

    localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      on_cnt_c;

    assign guard_done_c = (cnt_q == CNT_W'(GUARD_CYCLES - 1));
    assign slot_done_c  = (cnt_q == CNT_W'(SLOT_CYCLES - 1));

    // Count restarts at every slot boundary and whenever scanning is not running.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!run || slot_done_c) begin
            cnt_d = '0;
        end
        // Position inside the ON interval for the coming cycle; only meaningful once past guard.
        on_cnt_c   = 32'(cnt_d) - 32'(GUARD_CYCLES);
        lit_next_c = ((on_cnt_c * 32'd16) < 32'(lit_limit));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Scans a snapshotted frame of per-digit segment patterns onto a shared bus with guard gaps.
// Optional SEVEN_SEG_SCAN_DIM_EN adds a 4-bit brightness input that shortens each digit's lit time.
module seven_seg_scan_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned GUARD_CYCLES = 500
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_in,
`ifdef SEVEN_SEG_SCAN_DIM_EN
    input  logic [3:0]                       brightness,
`endif
    output logic [SEG_W-1:0]                 seg_out,
    output logic [NUM_DIGITS-1:0]            an,
    output logic                             frame_start
);

    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned ON_LEN  = SLOT_CYCLES - GUARD_CYCLES;
    localparam int unsigned LIMIT_W = $clog2(ON_LEN * 16 + 1);

    scan_state_t                      state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] frame_q, frame_d;
    logic [SEG_W-1:0]                 seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0]            an_q, an_d;
    logic                             frame_start_q, frame_start_d;
    logic                             snap_c;
    logic                             run_c;
    logic                             guard_done_c;
    logic                             slot_done_c;
    logic                             lit_next_c;
    logic [LIMIT_W-1:0]               lit_limit_c;

`ifdef SEVEN_SEG_SCAN_DIM_EN
    logic [3:0] bright_q, bright_d;

    assign bright_d    = snap_c ? brightness : bright_q;
    assign lit_limit_c = LIMIT_W'(ON_LEN * (32'(bright_q) + 32'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            bright_q <= 4'hF;
        end else begin
            bright_q <= bright_d;
        end
    end
`else
    assign lit_limit_c = LIMIT_W'(ON_LEN * 16);
`endif

    assign run_c = en && (state_q != IDLE);

    scan_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .GUARD_CYCLES (GUARD_CYCLES),
        .LIMIT_W      (LIMIT_W)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .run          (run_c),
        .lit_limit    (lit_limit_c),
        .guard_done_c (guard_done_c),
        .slot_done_c  (slot_done_c),
        .lit_next_c   (lit_next_c)
    );

    // Next state, digit index, frame snapshot and the registered output image.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        frame_d       = frame_q;
        snap_c        = 1'b0;
        frame_start_d = 1'b0;
        an_d          = '1;
        seg_out_d     = SEG_BLANK;

        case (state_q)
            IDLE: begin
                snap_c  = 1'b1;
                state_d = GUARD;
            end
            GUARD: begin
                if (guard_done_c) begin
                    state_d = ON;
                end
            end
            ON: begin
                if (slot_done_c) begin
                    state_d = GUARD;
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        snap_c = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (snap_c) begin
            idx_d         = '0;
            frame_d       = seg_in;
            frame_start_d = 1'b1;
        end

        // Disable overrides everything: drop to IDLE and go dark without finishing the slot.
        if (!en) begin
            state_d       = IDLE;
            idx_d         = '0;
            frame_d       = frame_q;
            snap_c        = 1'b0;
            frame_start_d = 1'b0;
        end

        if ((state_d == ON) && lit_next_c) begin
            an_d[idx_d] = 1'b0;
            seg_out_d   = frame_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            frame_q       <= {NUM_DIGITS{SEG_BLANK}};
            seg_out_q     <= SEG_BLANK;
            an_q          <= '1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            frame_q       <= frame_d;
            seg_out_q     <= seg_out_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_out     = seg_out_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Bench for seven_seg_scan_mux: frame-position reference model feeding a per-cycle scoreboard.
module tb_seven_seg_scan_mux;

    localparam int unsigned N     = 4;
    localparam int unsigned S     = 8;
    localparam int unsigned G     = 2;
    localparam int unsigned FRAME = N * S;

    typedef struct packed {
        logic         fs;
        logic [N-1:0] an;
        logic [6:0]   seg;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en;
    logic [N-1:0][6:0]    seg_in;
    logic [6:0]           seg_out;
    logic [N-1:0]         an;
    logic                 frame_start;
`ifdef SEVEN_SEG_SCAN_DIM_EN
    logic [3:0]           brightness;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb_q[$];

    // Reference model: position within the frame since the last snapshot.
    logic              m_active;
    int unsigned       m_t;
    logic [N-1:0][6:0] m_frame;
    int unsigned       m_bright;
    int unsigned       lit_cnt;

    seven_seg_scan_mux #(
        .NUM_DIGITS   (N),
        .SLOT_CYCLES  (S),
        .GUARD_CYCLES (G)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .seg_in      (seg_in),
`ifdef SEVEN_SEG_SCAN_DIM_EN
        .brightness  (brightness),
`endif
        .seg_out     (seg_out),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Predict the outputs after the coming edge, then advance one clock and score the DUT.
    task automatic tick();
        exp_t        e;
        exp_t        o;
        int unsigned slot;
        int unsigned pos;
        e = '{fs: 1'b0, an: '1, seg: 7'h7F};
        if (reset || !en) begin
            m_active = 1'b0;
        end else begin
            if (!m_active || m_t == FRAME - 1) begin
                m_active = 1'b1;
                m_t      = 0;
                m_frame  = seg_in;
`ifdef SEVEN_SEG_SCAN_DIM_EN
                m_bright = 32'(brightness);
`else
                m_bright = 15;
`endif
                e.fs = 1'b1;
            end else begin
                m_t++;
            end
            slot = m_t / S;
            pos  = m_t % S;
            if (pos >= G && (pos - G) * 16 < (S - G) * (m_bright + 1)) begin
                e.an[slot] = 1'b0;
                e.seg      = m_frame[slot];
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        check("frame_start", 32'(frame_start), 32'(o.fs));
        check("an", 32'(an), 32'(o.an));
        check("seg_out", 32'(seg_out), 32'(o.seg));
        if (an != '1) lit_cnt++;
    endtask

    // Run until the model is inside the ON part of the given digit; bounded.
    task automatic run_to_on(input int unsigned digit, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if (m_active && (m_t / S) == digit && (m_t % S) >= G + 1) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        m_active = 1'b0;
        m_t      = 0;
        m_frame  = '1;
        m_bright = 15;
        lit_cnt  = 0;
        reset    = 1'b1;
        en       = 1'b1;
        seg_in   = {7'h79, 7'h24, 7'h30, 7'h40};
`ifdef SEVEN_SEG_SCAN_DIM_EN
        brightness = 4'hF;
`endif

        // Reset held with en high stays dark.
        repeat (3) tick();
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg_out), 32'h7F);

        // Normal scan; seg_in[0] changes mid-frame and must wait for the next snapshot.
        reset = 1'b0;
        repeat (10) tick();
        seg_in[0] = 7'h19;
        repeat (FRAME * 2) tick();

        // Disable during ON of digit 2, then restart at digit 0.
        run_to_on(2, "reach_on_d2");
        en = 1'b0;
        tick();
        check("en_off_an", 32'(an), 32'hF);
        check("en_off_seg", 32'(seg_out), 32'h7F);
        tick();
        en = 1'b1;
        tick();
        check("reenable_fs", 32'(frame_start), 32'd1);
        repeat (FRAME + 4) tick();

        // Reset during ON of digit 1.
        run_to_on(1, "reach_on_d1");
        reset = 1'b1;
        tick();
        check("midreset_an", 32'(an), 32'hF);
        tick();
        reset = 1'b0;
        repeat (FRAME + 6) tick();

`ifdef SEVEN_SEG_SCAN_DIM_EN
        // Half brightness: 3 of 6 ON cycles per digit; then full brightness.
        en = 1'b0;
        brightness = 4'd7;
        tick();
        en = 1'b1;
        lit_cnt = 0;
        repeat (FRAME) tick();
        check("dim7_lit_cycles", 32'(lit_cnt), 32'(N * 3));
        en = 1'b0;
        brightness = 4'd15;
        tick();
        en = 1'b1;
        lit_cnt = 0;
        repeat (FRAME) tick();
        check("dim15_lit_cycles", 32'(lit_cnt), 32'(N * (S - G)));
`endif

        // Random enable, occasional reset, and changing patterns.
        for (int i = 0; i < 300; i++) begin
            en    = ($urandom_range(0, 19) != 0);
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) begin
                for (int d = 0; d < N; d++) seg_in[d] = 7'($urandom_range(0, 127));
            end
`ifdef SEVEN_SEG_SCAN_DIM_EN
            if ($urandom_range(0, 15) == 0) brightness = 4'($urandom_range(0, 15));
`endif
            tick();
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
